// File: rtl/ir_op_executor_if.sv
// Op handshake, pixel input, frame RAM port and readout stream of ir_op_executor.
interface ir_op_executor_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 16
) ();
   logic [2:0]        iOp_Code;
   logic              oOp_Done;
   logic              oBusy;
   logic              oErr;
   logic              iPix_Valid;
   logic [DATA_W-1:0] iPix_Data;
   logic              oMem_We;
   logic              oMem_Re;
   logic [ADDR_W-1:0] oMem_Addr;
   logic [DATA_W-1:0] oMem_Wdata;
   logic [DATA_W-1:0] iMem_Rdata;
   logic              oOut_Valid;
   logic [DATA_W-1:0] oOut_Data;
   logic              iOut_Ready;

   modport slave (
      input  iOp_Code, iPix_Valid, iPix_Data, iMem_Rdata, iOut_Ready,
      output oOp_Done, oBusy, oErr, oMem_We, oMem_Re, oMem_Addr, oMem_Wdata, oOut_Valid, oOut_Data
   );

   modport master (
      output iOp_Code, iPix_Valid, iPix_Data, iMem_Rdata, iOut_Ready,
      input  oOp_Done, oBusy, oErr, oMem_We, oMem_Re, oMem_Addr, oMem_Wdata, oOut_Valid, oOut_Data
   );
endinterface

// File: rtl/ir_op_executor.sv
// Local-domain executor for CLEAR / CAPTURE / READOUT on a single-port frame RAM.
// Optional CAPTURE pixel-gap timeout enabled by IRSTORE_OP_TIMEOUT_EN.
module ir_op_executor #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned FRAME_WORDS = 768,
   parameter int unsigned STABLE_CYC  = 3,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input logic            iClk_Local,
   input logic            iRst,
   ir_op_executor_if.slave bus
);

   localparam int unsigned       CntW       = $clog2(STABLE_CYC);
   localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(FRAME_WORDS - 1);
   localparam logic [CntW-1:0]   LastSample = CntW'(STABLE_CYC - 1);

   if (STABLE_CYC < 2 || FRAME_WORDS < 1 || FRAME_WORDS > (1 << ADDR_W) || TIMEOUT_CYC < 1)
   begin : gParamCheck
      $error("ir_op_executor: illegal parameter set");
   end

   typedef enum logic [2:0] {
      StIdle, StQual, StClear, StCapture, StReadout, StDone, StRelease
   } stateT;

   stateT             stateQ, stateD;
   logic [2:0]        opQ, opD;
   logic [CntW-1:0]   cntQ, cntD;
   logic [ADDR_W-1:0] addrQ, addrD;
   logic [ADDR_W-1:0] outCntQ, outCntD;
   logic              errQ, errD;
   logic              pendQ, pendD;
   logic [DATA_W-1:0] pixQ, pixD;
   logic              rdDoneQ, rdDoneD;
   logic              inflightQ, inflightD;
   logic [DATA_W-1:0] fifoMemQ [2];
   logic [DATA_W-1:0] fifoMemD [2];
   logic              wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
   logic [1:0]        fifoCntQ, fifoCntD;
   logic [1:0]        occ;
   logic              pop, re, memWe;

`ifdef IRSTORE_OP_TIMEOUT_EN
   localparam int unsigned     GapW    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT_CYC - 1);
   logic [GapW-1:0] gapQ, gapD;
`endif

   always_comb begin
      stateD    = stateQ;
      opD       = opQ;
      cntD      = cntQ;
      addrD     = addrQ;
      outCntD   = outCntQ;
      errD      = errQ;
      pendD     = 1'b0;
      pixD      = pixQ;
      rdDoneD   = rdDoneQ;
      fifoMemD  = fifoMemQ;
      wrPtrD    = wrPtrQ;
      rdPtrD    = rdPtrQ;
`ifdef IRSTORE_OP_TIMEOUT_EN
      gapD      = gapQ;
`endif
      pop = (fifoCntQ != 2'd0) && bus.iOut_Ready;
      // Occupancy after this cycle's pop, so a full-rate stream keeps one read per cycle
      occ = fifoCntQ + {1'b0, inflightQ} - {1'b0, pop};
      re  = (stateQ == StReadout) && !rdDoneQ && (occ < 2'd2);
      inflightD = re;
      fifoCntD  = occ;
      if (inflightQ) begin
         fifoMemD[wrPtrQ] = bus.iMem_Rdata;
         wrPtrD           = ~wrPtrQ;
      end
      if (pop) rdPtrD = ~rdPtrQ;

      case (stateQ)
         StIdle: begin
            if (bus.iOp_Code != 3'b000) begin
               stateD = StQual;
               opD    = bus.iOp_Code;
               cntD   = '0;
            end
         end
         StQual: begin
            if (bus.iOp_Code != opQ) begin
               stateD = StIdle;
            end else if (cntQ == LastSample) begin
               errD    = 1'b0;
               addrD   = '0;
               outCntD = '0;
               rdDoneD = 1'b0;
`ifdef IRSTORE_OP_TIMEOUT_EN
               gapD    = '0;
`endif
               if (opQ[2]) begin
                  errD   = 1'b1;
                  stateD = StDone;
               end else begin
                  unique case (opQ[1:0])
                     2'b01:   stateD = StClear;
                     2'b10:   stateD = StCapture;
                     2'b11:   stateD = StReadout;
                     default: stateD = StIdle;
                  endcase
               end
            end else begin
               cntD = cntQ + CntW'(1);
            end
         end
         StClear: begin
            if (addrQ == LastAddr) stateD = StDone;
            else                   addrD  = addrQ + ADDR_W'(1);
         end
         StCapture: begin
            // Pixel is registered and written the following cycle
            pendD = bus.iPix_Valid;
            pixD  = bus.iPix_Data;
            if (pendQ) begin
               if (addrQ == LastAddr) begin
                  stateD = StDone;
                  pendD  = 1'b0;
               end else begin
                  addrD = addrQ + ADDR_W'(1);
               end
            end
`ifdef IRSTORE_OP_TIMEOUT_EN
            if (bus.iPix_Valid) begin
               gapD = '0;
            end else if (gapQ == GapLast) begin
               errD   = 1'b1;
               stateD = StDone;
               pendD  = 1'b0;
            end else begin
               gapD = gapQ + GapW'(1);
            end
`endif
         end
         StReadout: begin
            if (re) begin
               if (addrQ == LastAddr) rdDoneD = 1'b1;
               else                   addrD   = addrQ + ADDR_W'(1);
            end
            if (pop) begin
               if (outCntQ == LastAddr) stateD  = StDone;
               else                     outCntD = outCntQ + ADDR_W'(1);
            end
         end
         StDone: begin
            if (bus.iOp_Code == 3'b000) begin
               stateD = StRelease;
               cntD   = '0;
            end
         end
         StRelease: begin
            if (bus.iOp_Code != 3'b000)  stateD = StDone;
            else if (cntQ == LastSample) stateD = StIdle;
            else                         cntD   = cntQ + CntW'(1);
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge iClk_Local) begin
      if (iRst) begin
         stateQ    <= StIdle;
         opQ       <= '0;
         cntQ      <= '0;
         addrQ     <= '0;
         outCntQ   <= '0;
         errQ      <= 1'b0;
         pendQ     <= 1'b0;
         pixQ      <= '0;
         rdDoneQ   <= 1'b0;
         inflightQ <= 1'b0;
         fifoMemQ  <= '{default: '0};
         wrPtrQ    <= 1'b0;
         rdPtrQ    <= 1'b0;
         fifoCntQ  <= '0;
`ifdef IRSTORE_OP_TIMEOUT_EN
         gapQ      <= '0;
`endif
      end else begin
         stateQ    <= stateD;
         opQ       <= opD;
         cntQ      <= cntD;
         addrQ     <= addrD;
         outCntQ   <= outCntD;
         errQ      <= errD;
         pendQ     <= pendD;
         pixQ      <= pixD;
         rdDoneQ   <= rdDoneD;
         inflightQ <= inflightD;
         fifoMemQ  <= fifoMemD;
         wrPtrQ    <= wrPtrD;
         rdPtrQ    <= rdPtrD;
         fifoCntQ  <= fifoCntD;
`ifdef IRSTORE_OP_TIMEOUT_EN
         gapQ      <= gapD;
`endif
      end
   end

   assign memWe          = (stateQ == StClear) || ((stateQ == StCapture) && pendQ);
   assign bus.oBusy      = (stateQ != StIdle);
   assign bus.oOp_Done   = (stateQ == StDone) || (stateQ == StRelease);
   assign bus.oErr       = errQ;
   assign bus.oMem_We    = memWe;
   assign bus.oMem_Re    = re;
   assign bus.oMem_Addr  = (memWe || re) ? addrQ : '0;
   assign bus.oMem_Wdata = ((stateQ == StCapture) && pendQ) ? pixQ : '0;
   assign bus.oOut_Valid = (fifoCntQ != 2'd0);
   assign bus.oOut_Data  = (fifoCntQ != 2'd0) ? fifoMemQ[rdPtrQ] : '0;

endmodule
